// File: rtl/reg_dump_pkg.sv
// Constants and types shared by the register-dump reader and the register file.
package reg_dump_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_if.sv
// Control, register-file read port and output stream of the register-dump reader.
interface reg_dump_if;
  import reg_dump_pkg::*;

  logic              start;
  logic              abort;
  logic [IDX_W-1:0]  sr_select;
  logic [DATA_W-1:0] sr_data;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, sr_data, out_ready,
    output sr_select, out_data, out_idx, out_valid, busy, done
  );

  modport slave (
    output start, abort, sr_data, out_ready,
    input  sr_select, out_data, out_idx, out_valid, busy, done
  );

endinterface

// File: rtl/reg_dump.sv
// Walks R0..R(NUM_REGS-1) through one register-file read port and streams
// each captured word out on a valid/ready interface, two cycles per word.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input logic        Clk,
  input logic        Reset,
  reg_dump_if.master dif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [1:0]        state_q,     state_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;

    if (state_q != ST_IDLE && dif.abort) begin
      // out_data/out_idx deliberately keep the last captured word
      state_d     = ST_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dif.start && !dif.abort) begin
            idx_d   = '0;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          out_data_d  = dif.sr_data;
          out_idx_d   = idx_q;
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
        ST_SEND: begin
          if (dif.out_ready) begin
            out_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_READ;
            end
          end
        end
        default: begin
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign dif.sr_select = idx_q;
  assign dif.out_data  = out_data_q;
  assign dif.out_idx   = out_idx_q;
  assign dif.out_valid = out_valid_q;
  assign dif.busy      = (state_q != ST_IDLE);
  assign dif.done      = done_q;

endmodule
